// File: rtl/sr_excite_driver.sv
// Handshaked driver that turns target bits into single-cycle set/reset pulses for an SR flip-flop.
// Optional excitation statistics counters are enabled with `define SR_EXC_STATS_EN.
module sr_excite_driver #(
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    input  logic             qbar_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] rst_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        DRIVE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_n;
    logic [7:0] timer;
    logic [7:0] timer_n;
    logic       tgt;
    logic       tgt_n;
    logic       accept;
    logic       already_there;
    logic       fb_match;
    logic       s_n;
    logic       r_n;
    logic       busy_n;
    logic       done_n;
    logic       err_n;

    assign tgt_ready     = (state == IDLE);
    assign accept        = tgt_valid && tgt_ready;
    // Inconsistent feedback (q_fb == qbar_fb) never qualifies as reaching the target.
    assign already_there = (q_fb == tgt_bit) && (qbar_fb != tgt_bit);
    assign fb_match      = (q_fb == tgt) && (qbar_fb == !tgt);
    assign tgt_n         = accept ? tgt_bit : tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= 8'd0;
            s     <= 1'b0;
            r     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            s     <= s_n;
            r     <= r_n;
            busy  <= busy_n;
            done  <= done_n;
            err   <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tgt <= tgt_bit;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = already_there ? HOLD : DRIVE;
                    timer_n = 8'd0;
                end
            end
            HOLD:  state_n = IDLE;
            DRIVE: begin
                state_n = WAIT;
                timer_n = 8'd0;
            end
            WAIT: begin
                if (fb_match) begin
                    state_n = DONE;
                end else if (timer == TIMER_LAST) begin
                    state_n = ERR;
                end else begin
                    timer_n = timer + 8'd1;
                end
            end
            DONE:  state_n = IDLE;
            ERR: begin
                if (err_clr) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the state they describe.
    always_comb begin
        s_n    = (state_n == DRIVE) &&  tgt_n;
        r_n    = (state_n == DRIVE) && !tgt_n;
        busy_n = (state_n == HOLD) || (state_n == DRIVE) ||
                 (state_n == WAIT) || (state_n == DONE);
        done_n = (state_n == HOLD) || (state_n == DONE);
        err_n  = (state_n == ERR);
    end

`ifdef SR_EXC_STATS_EN
    logic [CNT_W-1:0] set_q;
    logic [CNT_W-1:0] rst_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            set_q <= '0;
            rst_q <= '0;
        end else if (state == DRIVE) begin
            if (tgt) begin
                set_q <= set_q + CNT_W'(1);
            end else begin
                rst_q <= rst_q + CNT_W'(1);
            end
        end
    end

    assign set_cnt = set_q;
    assign rst_cnt = rst_q;
`else
    assign set_cnt = '0;
    assign rst_cnt = '0;
`endif

endmodule
